// File: rtl/fifo_read_fwft.sv
// Read-side FWFT adapter for the async FIFO: pops, captures, and presents a
// valid/ready head word via a 2-deep skid. Option: FWFT_WORD_COUNT_EN.
module fifo_read_fwft #(
    parameter int dataWidth = 8,
    parameter int cntWidth  = 16
) (
    input  logic                 readClkIn,
    input  logic                 readRstIn,
    input  logic                 fifoEmptyIn,
    output logic                 fifoReadEnOut,
    input  logic [dataWidth-1:0] fifoDataIn,
    output logic                 outValid,
    output logic [dataWidth-1:0] outData,
    input  logic                 outReady,
    output logic [1:0]           occupancyOut
`ifdef FWFT_WORD_COUNT_EN
    ,
    output logic [cntWidth-1:0]  wordCountOut
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e               count_q, count_d;
    logic                 pending_q, pending_d;
    logic [dataWidth-1:0] head_q, head_d;
    logic [dataWidth-1:0] skid_q, skid_d;

    logic       drain;
    logic [2:0] cnt_sum;

    assign outValid     = (count_q != EMPTY);
    assign outData      = head_q;
    assign occupancyOut = count_q;
    assign drain        = outValid & outReady;

    // Words held after this edge, counting the one landing now.
    assign cnt_sum = {1'b0, count_q} + {2'b0, pending_q} - {2'b0, drain};

    // outReady reaches the pop request combinationally so a full
    // buffer being drained can still refill every cycle.
    assign fifoReadEnOut = readRstIn & ~fifoEmptyIn & (cnt_sum < 3'd2);
    assign pending_d     = fifoReadEnOut & ~fifoEmptyIn;
    assign count_d       = state_e'(cnt_sum[1:0]);

    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        unique case (count_q)
            EMPTY: begin
                if (pending_q) head_d = fifoDataIn;
            end
            ONE: begin
                if (pending_q) begin
                    if (drain) head_d = fifoDataIn;
                    else       skid_d = fifoDataIn;
                end
            end
            TWO: begin
                if (drain) begin
                    head_d = skid_q;
                    if (pending_q) skid_d = fifoDataIn;
                end
            end
            default: begin
                head_d = head_q;
            end
        endcase
    end

    always_ff @(posedge readClkIn or negedge readRstIn) begin
        if (!readRstIn) begin
            count_q   <= EMPTY;
            pending_q <= 1'b0;
            head_q    <= '0;
            skid_q    <= '0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
            head_q    <= head_d;
            skid_q    <= skid_d;
        end
    end

    // A word must never land on a full buffer that is not draining.
    a_no_overflow : assert property (
        @(posedge readClkIn) disable iff (!readRstIn)
        !(pending_q && (count_q == TWO) && !drain)
    );

`ifdef FWFT_WORD_COUNT_EN
    logic [cntWidth-1:0] words_q;

    always_ff @(posedge readClkIn or negedge readRstIn) begin
        if (!readRstIn) words_q <= '0;
        else if (drain) words_q <= words_q + cntWidth'(1);
    end

    assign wordCountOut = words_q;
`else
    logic [cntWidth-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule
